wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
Writeback arbiter that sits directly upstream of the general register file's single write port.
- Merges two result producers onto that one write port:
  - the single-cycle ALU result;
  - the long-latency result from the LSU/MDU.
- Buffers LSU results in a small FIFO and arbitrates with starvation protection.
- Drives a registered wen/waddr/wdata triple to the register file.

Parameters:
XLEN, 64, data width of results and write port
DEPTH, 2, LSU-side FIFO entries; power of 2, >=2
STARVE_MAX, 4, max consecutive ALU grants while FIFO non-empty; >=1

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted this cycle (valid&&ready)
alu_wen  in  1  ALU result writes a register
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
lsu_valid  in  1  LSU/MDU result valid
lsu_ready  out  1  FIFO can accept
lsu_wen  in  1  LSU result writes a register
lsu_rd  in  5  LSU destination register
lsu_data  in  XLEN  LSU result
wen  out  1  register-file write enable (registered)
waddr  out  5  register-file write address (registered)
wdata  out  XLEN  register-file write data (registered)

Behaviour:
- Reset (synchronous, active-high):
  - wen=0, waddr=0, wdata=0.
  - FIFO emptied (pointers 0, count 0), starve_cnt=0.
  - Reset mid-operation discards all buffered entries; no stale write is issued afterwards.
- FIFO:
  - lsu_ready = !full, combinational from count only.
  - Push on lsu_valid&&lsu_ready; stores {wen, rd, data}.
  - No write-through: an entry pushed in cycle N is poppable at earliest in cycle N+1.
  - Pointers wrap mod DEPTH; count width is clog2(DEPTH+1).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: no push, even if a pop occurs that cycle.
- Arbitration (combinational each cycle):
  - grant_fifo = !empty && (!alu_valid || full || starve_cnt==STARVE_MAX).
  - grant_alu = alu_valid && !grant_fifo.
  - alu_ready = !grant_fifo; alu_ready=1 when FIFO empty.
  - Pop when grant_fifo.
- starve_cnt:
  - Cleared on reset, on pop, or when the FIFO is empty.
  - Incremented when grant_alu && !empty.
  - Saturates at STARVE_MAX.
- Output register, updated every cycle:
  - If grant_fifo: wen <= head.wen && head.rd!=0; waddr <= head.rd; wdata <= head.data.
  - Else if grant_alu: same from the alu_* fields.
  - Else: wen <= 0; waddr and wdata hold their values.
- Entries with wen=0 or rd=0 are consumed normally (handshake completes, arbitration slot used) but produce wen=0.
- Latency:
  - ALU accept in cycle N gives wen in cycle N+1.
  - LSU push into an empty FIFO with no ALU traffic in cycle N gives wen in cycle N+2.
- Ordering:
  - LSU results retire in push order.
  - ALU results retire in accept order.
  - No ordering between the two streams is guaranteed; issue logic prevents same-rd WAW.
- At most one register write per cycle.

Optional Feature:
Macro WB_ARBITER_PERF_EN.
- Defined: adds three outputs, each 32 bits, zeroed on reset, wrapping on overflow:
  - perf_alu_cnt, incremented on every ALU grant;
  - perf_lsu_cnt, incremented on every FIFO pop;
  - perf_stall_cnt, incremented each cycle alu_valid && !alu_ready.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ALU only:
  - Stimulus: alu_valid=1, alu_wen=1, rd=5, data=0x1234 in cycle 0.
  - Response: cycle 1 wen=1, waddr=5, wdata=0x1234; cycle 2 wen=0.
- LSU only:
  - Stimulus: lsu push with rd=7, data=0xDEAD in cycle 0, FIFO empty.
  - Response: lsu_ready=1; cycle 1 pop; cycle 2 wen=1, waddr=7, wdata=0xDEAD.
- Starvation (STARVE_MAX=4):
  - Stimulus: one FIFO entry, alu_valid held high.
  - Response: 4 ALU grants, then alu_ready=0 for one cycle while the FIFO entry is written; ALU grants resume after.
- FIFO full (DEPTH=2):
  - Stimulus: 2 LSU pushes while ALU continuously valid.
  - Response: lsu_ready=0 the cycle after the 2nd push; FIFO granted over ALU until not full; writes emerge in push order.
- x0 and no-write:
  - Stimulus: ALU rd=0, wen=1; then LSU rd=9, wen=0.
  - Response: both handshakes complete; wen output stays 0 for both.
- Reset mid-operation:
  - Stimulus: FIFO holding 2 entries, reset asserted 1 cycle.
  - Response: next cycle wen=0 and lsu_ready=1; no buffered entry is ever written.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and FIFO-buffered LSU/MDU results onto
// the one register-file write port. Optional perf counters enabled by WB_ARBITER_PERF_EN.
module wb_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic            alu_wen,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic            lsu_wen,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wen,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata
`ifdef WB_ARBITER_PERF_EN
  ,
  output logic [31:0]     perf_alu_cnt,
  output logic [31:0]     perf_lsu_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  localparam logic [CntW-1:0] CntFull   = CntW'(DEPTH);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_MAX);

  typedef struct packed {
    logic            wen;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic empty, full, push, pop, grant_fifo, grant_alu;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CntFull);
  assign lsu_ready  = !full;
  assign push       = lsu_valid && !full;
  assign grant_fifo = !empty && (!alu_valid || full || (starve_q == StarveMax));
  assign grant_alu  = alu_valid && !grant_fifo;
  assign alu_ready  = !grant_fifo;
  assign pop        = grant_fifo;
  assign head       = mem_q[rd_ptr_q];

  // Storage is written only on push; entry validity is tracked by count, so no reset needed.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{wen: lsu_wen, rd: lsu_rd, data: lsu_data};
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (grant_alu && (starve_q != StarveMax)) begin
      starve_d = starve_q + StW'(1);
    end
  end

  // Writes to x0 or with wen clear still consume the slot but never assert the write enable.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant_fifo) begin
      wen_d   = head.wen && (head.rd != 5'd0);
      waddr_d = head.rd;
      wdata_d = head.data;
    end else if (grant_alu) begin
      wen_d   = alu_wen && (alu_rd != 5'd0);
      waddr_d = alu_rd;
      wdata_d = alu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

`ifdef WB_ARBITER_PERF_EN
  logic [31:0] perf_alu_q, perf_alu_d;
  logic [31:0] perf_lsu_q, perf_lsu_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_alu_d   = perf_alu_q + {31'd0, grant_alu};
    perf_lsu_d   = perf_lsu_q + {31'd0, pop};
    perf_stall_d = perf_stall_q + {31'd0, alu_valid && !alu_ready};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_alu_q   <= '0;
      perf_lsu_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_alu_q   <= perf_alu_d;
      perf_lsu_q   <= perf_lsu_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_alu_cnt   = perf_alu_q;
  assign perf_lsu_cnt   = perf_lsu_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
